muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU; executes the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the ALU in the execute stage; the core stalls on in_ready/out_valid.
- Radix-2 iterative datapath: one partial product or restoring-division step per cycle.
- Valid/ready handshake on both input and output, plus a synchronous flush.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of any in-flight operation
- in_valid  input  1  operands/op presented
- in_ready  output  1  unit can accept (high only in IDLE)
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  WIDTH  rs1 operand
- b  input  WIDTH  rs2 operand
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  consumer takes result
- result  output  WIDTH  result, held stable while out_valid=1
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; counter and accumulators cleared.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on in_valid && in_ready && !flush. Latch op, sign flags, operand magnitudes; counter=WIDTH.
  - IDLE -> DONE directly for special cases (below).
  - CALC: one step per cycle; counter decrements. When the counter reaches 0, apply sign correction, register the result, and go to DONE.
  - DONE -> IDLE on out_ready. No new accept in the same cycle: in_ready is low in DONE.
- Latency: acceptance at edge t gives out_valid high from edge t+WIDTH+1 for normal ops, and from edge t+1 for special cases.
- Signedness:
  - MULH and DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - The core computes on magnitudes; the sign is applied at the final step.
- Multiply: 2*WIDTH-bit product. MUL returns the low WIDTH bits; the MULH variants return the high WIDTH bits.
- Division: restoring; quotient and remainder both kept.
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases (single cycle, straight to DONE):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> a.
  - Signed overflow (a = -2^(WIDTH-1), b = -1): DIV -> a; REM -> 0.
- flush:
  - In CALC or DONE: state -> IDLE at the next edge, out_valid low, result discarded.
  - In IDLE: flush wins over in_valid; nothing is accepted.
- Input stability: a, b and op are sampled only at acceptance; later changes have no effect.
- Output stability: result and out_valid are held unchanged while out_ready=0.
- Width: all arithmetic is modulo 2^WIDTH; the MULH product is computed at full 2*WIDTH bits with no truncation before selection.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings (OP_MUL..OP_REMU);
  - FSM state encoding (S_IDLE, S_CALC, S_DONE);
  - helper function is_div(op).
- One natural sub-module: muldiv_core, a single-step datapath (shift-add / restore-subtract per cycle plus counter). The top level holds the FSM, handshake, special-case detection and sign fix-up.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD), WIDTH=32 -> result 0xFFFFFFEB; out_valid first high 33 cycles after accept; in_ready low throughout.
- MULH/MULHSU/MULHU with a=0x80000000, b=0xFFFFFFFF -> 0x00000000, 0x80000000 and 0x7FFFFFFF respectively.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- DIVU a=5, b=0 -> 0xFFFFFFFF at t+1; REM a=5, b=0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable, in_ready=0. Then out_ready=1 -> IDLE next cycle and a new accept on the following cycle.
- flush in mid-CALC (cycle 10) -> IDLE next edge, no out_valid. Assert rst_n=0 mid-CALC -> immediate async return to reset values. A subsequent MUL 6*7 -> 42.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 op codes,
// FSM states and the divide-class helper.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic is_div(input op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// Master drives operands, flush and out_ready; slave returns handshake, result and busy.
interface muldiv_if #(parameter int WIDTH = 32);
   import muldiv_pkg::*;

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   op_e              op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             busy;

   modport master (
      output flush, in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  flush, in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, busy
   );

endinterface

// File: rtl/muldiv_core.sv
// Radix-2 magnitude datapath: one shift-add (multiply) or restore-subtract (divide) step
// per cycle while cnt != 0; WIDTH steps after load. No backpressure, the owner sequences it.
module muldiv_core #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clear,
   input  logic             div_mode,
   input  logic [WIDTH-1:0] opnd,
   input  logic [WIDTH-1:0] init_lo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [CNT_W-1:0] cnt
);

   logic [WIDTH-1:0] acc, lo_r, opnd_r, acc_n, lo_n;
   logic [CNT_W-1:0] cnt_r;
   logic             mode_r;
   logic [WIDTH:0]   mul_sum, shifted;
   logic             fits;

   // Multiply: {acc,lo} is the running product, multiplier bits consumed from lo[0].
   // Divide: acc is the partial remainder, lo shifts dividend out and quotient in.
   always_comb begin
      mul_sum = {1'b0, acc} + (lo_r[0] ? {1'b0, opnd_r} : '0);
      shifted = {acc, lo_r[WIDTH-1]};
      fits    = (shifted >= {1'b0, opnd_r});
      acc_n   = '0;
      lo_n    = '0;
      if (mode_r) begin
         acc_n = fits ? (shifted[WIDTH-1:0] - opnd_r) : shifted[WIDTH-1:0];
         lo_n  = {lo_r[WIDTH-2:0], fits};
      end else begin
         acc_n = mul_sum[WIDTH:1];
         lo_n  = {mul_sum[0], lo_r[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         lo_r   <= '0;
         opnd_r <= '0;
         cnt_r  <= '0;
         mode_r <= 1'b0;
      end else if (clear) begin
         acc    <= '0;
         lo_r   <= '0;
         opnd_r <= '0;
         cnt_r  <= '0;
         mode_r <= 1'b0;
      end else if (load) begin
         acc    <= '0;
         lo_r   <= init_lo;
         opnd_r <= opnd;
         cnt_r  <= CNT_W'(WIDTH);
         mode_r <= div_mode;
      end else if (cnt_r != '0) begin
         acc    <= acc_n;
         lo_r   <= lo_n;
         cnt_r  <= cnt_r - CNT_W'(1);
      end
   end

   assign hi  = acc;
   assign lo  = lo_r;
   assign cnt = cnt_r;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: result WIDTH+1 cycles after accept, 1 cycle for div-by-zero/overflow.
// Accepts only in IDLE; result and out_valid hold in DONE until out_ready; flush aborts.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int  WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input logic     clk,
   input logic     rst_n,
   muldiv_if.slave bus
);

   state_e           state;
   op_e              op_r;
   logic             neg_q, neg_r;
   logic             in_ready_r, out_valid_r, busy_r;
   logic [WIDTH-1:0] result_r;

   logic             a_sgn, b_sgn, a_neg, b_neg, div_zero, ovf, special, accept;
   logic [WIDTH-1:0] a_mag, b_mag, spec_res, core_opnd, core_lo_init, hi, lo, fin;
   logic [CNT_W-1:0] cnt;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      a_sgn    = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                 (bus.op == OP_DIV)  || (bus.op == OP_REM);
      b_sgn    = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
      a_neg    = a_sgn && bus.a[WIDTH-1];
      b_neg    = b_sgn && bus.b[WIDTH-1];
      a_mag    = a_neg ? -bus.a : bus.a;
      b_mag    = b_neg ? -bus.b : bus.b;
      div_zero = is_div(bus.op) && (bus.b == '0);
      ovf      = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                 (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
      special  = div_zero || ovf;
      // op[1] separates REM/REMU from DIV/DIVU
      if (div_zero) spec_res = bus.op[1] ? bus.a : '1;
      else          spec_res = bus.op[1] ? '0 : bus.a;
      core_opnd    = is_div(bus.op) ? b_mag : a_mag;
      core_lo_init = is_div(bus.op) ? a_mag : b_mag;
      accept       = bus.in_valid && in_ready_r && !bus.flush;
   end

   muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept && !special),
      .clear    (bus.flush),
      .div_mode (is_div(bus.op)),
      .opnd     (core_opnd),
      .init_lo  (core_lo_init),
      .hi       (hi),
      .lo       (lo),
      .cnt      (cnt)
   );

   always_comb begin
      prod = neg_q ? -{hi, lo} : {hi, lo};
      case (op_r)
         OP_MUL:                      fin = prod[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin = prod[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:             fin = neg_q ? -lo : lo;
         default:                     fin = neg_r ? -hi : hi;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         op_r        <= OP_MUL;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         result_r    <= '0;
      end else if (bus.flush) begin
         state       <= S_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               op_r       <= bus.op;
               neg_q      <= a_neg ^ b_neg;
               neg_r      <= a_neg;
               in_ready_r <= 1'b0;
               busy_r     <= 1'b1;
               if (special) begin
                  result_r    <= spec_res;
                  out_valid_r <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  state <= S_CALC;
               end
            end
            S_CALC: if (cnt == '0) begin
               result_r    <= fin;
               out_valid_r <= 1'b1;
               state       <= S_DONE;
            end
            S_DONE: if (bus.out_ready) begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               busy_r      <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.result    = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32: directed RV32M vectors, handshake,
// flush and async reset scenarios, then random operations against a reference model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [W-1:0] sb[$];

   muldiv_if #(.WIDTH(W)) bus ();

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_res(input op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa = $signed(a);
      longint sbv = $signed(b);
      longint ub = longint'({32'b0, b});
      logic [63:0] p;
      logic [W-1:0] r;
      p = '0;
      r = '0;
      case (o)
         OP_MUL:    begin p = sa * sbv; r = p[31:0];  end
         OP_MULH:   begin p = sa * sbv; r = p[63:32]; end
         OP_MULHSU: begin p = sa * ub;  r = p[63:32]; end
         OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         OP_DIV:    r = (b == 0) ? '1 : W'(sa / sbv);
         OP_DIVU:   r = (b == 0) ? '1 : a / b;
         OP_REM:    r = (b == 0) ? a  : W'(sa % sbv);
         default:   r = (b == 0) ? a  : a % b;
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
      if (o[2] && b == 0) return 1;
      if ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return W + 1;
   endfunction

   // Leaves the unit in DONE; the caller decides when to take the result.
   task automatic do_op(input op_e o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ex, input int lat, input string tag);
      int          cyc;
      bit          ir_seen;
      logic [W-1:0] exp_v;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = o;
      bus.a        = av;
      bus.b        = bv;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.op       = op_e'(3'($urandom_range(0, 7)));
      bus.a        = $urandom;
      bus.b        = $urandom;
      sb.push_back(ex);
      cyc     = 0;
      ir_seen = 1'b0;
      do begin
         if (bus.in_ready) ir_seen = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
      end while (!bus.out_valid && cyc < 100);
      chk({tag, "_lat"}, 64'(cyc), 64'(lat));
      chk({tag, "_inrdy_low"}, 64'(ir_seen), 64'd0);
      exp_v = sb.pop_front();
      chk(tag, 64'(bus.result), 64'(exp_v));
   endtask

   task automatic consume();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] ra, rb, bp_exp;
      op_e          ro;
      bit           ok, seen;

      rst_n         = 1'b0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op        = OP_MUL;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_result", 64'(bus.result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7xm3");    consume();
      do_op(OP_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh");        consume();
      do_op(OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "mulhsu");      consume();
      do_op(OP_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33, "mulhu");       consume();
      do_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_m7_2");    consume();
      do_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem_m7_2");    consume();
      do_op(OP_DIVU,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33, "divu");        consume();
      do_op(OP_REMU,   32'hFFFF_FFF9, 32'd2,         32'd1,         33, "remu");        consume();
      do_op(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "divu_by0");    consume();
      do_op(OP_REM,    32'd5,         32'd0,         32'd5,         1,  "rem_by0");     consume();
      do_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");     consume();
      do_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf");     consume();

      // Backpressure: result must stay put for 10 cycles with out_ready low.
      bp_exp = ref_res(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
      do_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, bp_exp, 33, "bp");
      ok = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b1 || bus.result !== bp_exp || bus.in_ready !== 1'b0) ok = 1'b0;
      end
      chk("bp_stable", 64'(ok), 64'd1);
      consume();
      chk("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
      chk("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);
      do_op(OP_MUL, 32'd3, 32'd5, 32'd15, 33, "bp_next"); consume();

      // Flush at cycle 10 of CALC.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = OP_MUL; bus.a = 32'd9; bus.b = 32'd9;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      chk("flush_busy", 64'(bus.busy), 64'd0);
      chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("flush_no_out", 64'(seen), 64'd0);

      // Flush beats in_valid in IDLE.
      @(negedge clk);
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.a = 32'd8; bus.b = 32'd0;
      @(posedge clk);
      #1;
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      chk("flush_idle_busy", 64'(bus.busy), 64'd0);
      chk("flush_idle_out_valid", 64'(bus.out_valid), 64'd0);

      // Asynchronous reset mid-CALC.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = OP_DIV; bus.a = 32'd100; bus.b = 32'd7;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_result", 64'(bus.result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(OP_MUL, 32'd6, 32'd7, 32'd42, 33, "mul_6x7"); consume();

      for (int i = 0; i < 16; i++) begin
         ro = op_e'(3'($urandom_range(0, 7)));
         ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         case ($urandom_range(0, 4))
            0:       rb = '0;
            1:       rb = 32'($urandom_range(1, 9));
            default: rb = $urandom;
         endcase
         do_op(ro, ra, rb, ref_res(ro, ra, rb), ref_lat(ro, ra, rb), "rand");
         consume();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
